// File: rtl/jesd_pkg.sv
// Shared types and default sizing for the JESD LMFC generator slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package jesd_pkg;

  // WAIT: counter free-runs, waiting for the first SYSREF edge.
  // ALIGNED: phase set by SYSREF; later edges are checked against it.
  // LOCKED: one-shot alignment done; later SYSREF edges are ignored.
  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_ALIGNED = 2'd1,
    ST_LOCKED  = 2'd2
  } lmfc_state_t;

  localparam int LMFC_PERIOD_DEF = 16;
  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/jesd_sysref_sync.sv
// SYSREF synchroniser plus rising-edge detector on coreclk.
// Latency: sysref_edge is high in the cycle after SYNC_STAGES edges have seen sysref_i=1.
// Backpressure: none; sysref_edge is a one-cycle pulse per rising edge.
//
// Ports:
//   coreclk      in   core clock
//   rst_n        in   async active-low reset; all flops clear to 0
//   sysref_i     in   raw SYSREF from the board
//   sysref_edge  out  one-cycle pulse on a synchronised rising edge
module jesd_sysref_sync
  import jesd_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic coreclk,
  input  logic rst_n,
  input  logic sysref_i,
  output logic sysref_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Clearing the chain to 0 means a SYSREF already high when reset releases
  // still produces exactly one edge.
  always_ff @(posedge coreclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sysref_i};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Decoded straight from flops so the top level can act on the very next edge.
  assign sysref_edge = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/jesd_lmfc_gen.sv
// LMFC phase counter with SYSREF alignment, boundary pulse and sticky status flags.
// Latency: sysref_i sampled high -> lmfc_cnt_o==offset after SYNC_STAGES+1 coreclk edges.
// Backpressure: none; the counter free-runs and SYSREF events are never stalled.
//
// Ports:
//   coreclk            in   core clock, single domain
//   rst_n              in   async active-low reset
//   sysref_i           in   raw SYSREF
//   cfg_oneshot_i      in   1: align on first SYSREF only
//   cfg_lmfc_offset_i  in   counter value loaded at alignment (0 if out of range)
//   clear_i            in   clear sticky flags, return to WAIT
//   lmfc_cnt_o         out  LMFC phase 0..LMFC_PERIOD-1
//   lmfc_edge_o        out  high while lmfc_cnt_o==0
//   lmfc_aligned_o     out  state is ALIGNED or LOCKED
//   sysref_seen_o      out  sticky: SYSREF edge seen
//   sysref_misalign_o  out  sticky: off-phase SYSREF while ALIGNED
module jesd_lmfc_gen
  import jesd_pkg::*;
#(
  parameter int LMFC_PERIOD = LMFC_PERIOD_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             coreclk,
  input  logic             rst_n,
  input  logic             sysref_i,
  input  logic             cfg_oneshot_i,
  input  logic [CNT_W-1:0] cfg_lmfc_offset_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] lmfc_cnt_o,
  output logic             lmfc_edge_o,
  output logic             lmfc_aligned_o,
  output logic             sysref_seen_o,
  output logic             sysref_misalign_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LMFC_PERIOD - 1);
  // One bit wider so LMFC_PERIOD == 2**CNT_W is representable.
  localparam logic [CNT_W:0]   PERIOD_X = (CNT_W + 1)'(LMFC_PERIOD);

  lmfc_state_t      state;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] off_eff;
  logic [CNT_W-1:0] off_prev;
  logic             phase_ok;
  logic             aligned_q;
  logic             seen_q;
  logic             misalign_q;
  logic             sysref_edge;

  jesd_sysref_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .coreclk     (coreclk),
    .rst_n       (rst_n),
    .sysref_i    (sysref_i),
    .sysref_edge (sysref_edge)
  );

  assign cnt_inc = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

  // Out-of-range offsets fall back to phase 0.
  assign off_eff = ({1'b0, cfg_lmfc_offset_i} < PERIOD_X) ? cfg_lmfc_offset_i : '0;

  // A SYSREF is in phase when the counter is one step short of the offset,
  // i.e. its natural advance lands exactly where a reload would put it.
  assign off_prev = (off_eff == '0) ? CNT_LAST : off_eff - CNT_W'(1);
  assign phase_ok = (cnt_q == off_prev);

  always_ff @(posedge coreclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_WAIT;
      cnt_q      <= '0;
      aligned_q  <= 1'b0;
      seen_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      cnt_q <= cnt_inc;
      // clear_i takes priority; a coincident SYSREF edge is dropped.
      if (clear_i) begin
        state      <= ST_WAIT;
        aligned_q  <= 1'b0;
        seen_q     <= 1'b0;
        misalign_q <= 1'b0;
      end else if (sysref_edge) begin
        case (state)
          ST_WAIT: begin
            cnt_q     <= off_eff;
            seen_q    <= 1'b1;
            aligned_q <= 1'b1;
            state     <= cfg_oneshot_i ? ST_LOCKED : ST_ALIGNED;
          end
          ST_ALIGNED: begin
            seen_q <= 1'b1;
            if (!phase_ok) begin
              misalign_q <= 1'b1;
              cnt_q      <= off_eff;
            end
          end
          ST_LOCKED: begin
          end
          default: begin
            state     <= ST_WAIT;
            aligned_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign lmfc_cnt_o        = cnt_q;
  // Gated by reset so every output reads 0 while rst_n is low.
  assign lmfc_edge_o       = rst_n & (cnt_q == '0);
  assign lmfc_aligned_o    = aligned_q;
  assign sysref_seen_o     = seen_q;
  assign sysref_misalign_o = misalign_q;

endmodule

// File: tb/tb_jesd_lmfc_gen.sv
// Directed bench for jesd_lmfc_gen with a cycle-tagged scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_jesd_lmfc_gen;

  localparam int P = 16;
  localparam int W = 8;

  logic         coreclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sysref_i = 1'b0;
  logic         cfg_oneshot_i = 1'b0;
  logic [W-1:0] cfg_lmfc_offset_i = '0;
  logic         clear_i = 1'b0;
  logic [W-1:0] lmfc_cnt_o;
  logic         lmfc_edge_o;
  logic         lmfc_aligned_o;
  logic         sysref_seen_o;
  logic         sysref_misalign_o;

  jesd_lmfc_gen #(
    .LMFC_PERIOD (P),
    .CNT_W       (W),
    .SYNC_STAGES (2)
  ) dut (
    .coreclk           (coreclk),
    .rst_n             (rst_n),
    .sysref_i          (sysref_i),
    .cfg_oneshot_i     (cfg_oneshot_i),
    .cfg_lmfc_offset_i (cfg_lmfc_offset_i),
    .clear_i           (clear_i),
    .lmfc_cnt_o        (lmfc_cnt_o),
    .lmfc_edge_o       (lmfc_edge_o),
    .lmfc_aligned_o    (lmfc_aligned_o),
    .sysref_seen_o     (sysref_seen_o),
    .sysref_misalign_o (sysref_misalign_o)
  );

  always #5 coreclk = ~coreclk;

  int cyc = 0;
  always @(posedge coreclk) cyc <= cyc + 1;

  typedef struct {
    int           at;
    logic [127:0] nm;
    logic [W-1:0] cnt;
    logic         ev;
    logic         al;
    logic         se;
    logic         mi;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  // Counter phase reference: at cycle ph_cyc the counter reads ph_val.
  int   ph_cyc = 0;
  int   ph_val = 0;

  function automatic logic [W-1:0] exp_cnt(input int c);
    int d;
    d = (ph_val + (c - ph_cyc)) % P;
    return W'(d);
  endfunction

  function automatic void push(input int at, input logic [127:0] nm, input logic [W-1:0] cv,
                               input logic ev, input logic al, input logic se, input logic mi);
    exp_t e;
    e.at = at; e.nm = nm; e.cnt = cv; e.ev = ev; e.al = al; e.se = se; e.mi = mi;
    sbq.push_back(e);
  endfunction

  // Expectation while running: counter from the phase reference, edge when it is 0.
  function automatic void push_run(input int at, input logic [127:0] nm,
                                   input logic al, input logic se, input logic mi);
    logic [W-1:0] cv;
    cv = exp_cnt(at);
    push(at, nm, cv, (cv == '0), al, se, mi);
  endfunction

  // Monitor: pops every expectation due at this cycle and compares.
  always @(negedge coreclk) begin : mon
    exp_t e;
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      e = sbq.pop_front();
      if (e.at < cyc) begin
        total++; bad++;
        $display("FAIL %0s: check for cycle %0d missed (now %0d)", e.nm, e.at, cyc);
      end else begin
        total++;
        if (lmfc_cnt_o !== e.cnt) begin
          bad++;
          $display("FAIL %0s cnt @%0d: got %0d want %0d", e.nm, cyc, lmfc_cnt_o, e.cnt);
        end
        total++;
        if (lmfc_edge_o !== e.ev) begin
          bad++;
          $display("FAIL %0s edge @%0d: got %b want %b", e.nm, cyc, lmfc_edge_o, e.ev);
        end
        total++;
        if ({lmfc_aligned_o, sysref_seen_o, sysref_misalign_o} !== {e.al, e.se, e.mi}) begin
          bad++;
          $display("FAIL %0s flags(al,seen,mis) @%0d: got %b%b%b want %b%b%b", e.nm, cyc,
                   lmfc_aligned_o, sysref_seen_o, sysref_misalign_o, e.al, e.se, e.mi);
        end
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge coreclk);
  endtask

  task automatic pulse(input int len);
    sysref_i = 1'b1;
    repeat (len) @(negedge coreclk);
    sysref_i = 1'b0;
  endtask

  initial begin
    int c, t, ts, k, p1, p2, p3, p4, p5, p6, p7, k2, p8, r;

    // 1. Reset with SYSREF toggling: everything 0, then free-run 0..15.
    push(2, "reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3, "reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (cyc < 4) begin
      @(negedge coreclk);
      sysref_i = ~sysref_i;
    end
    sysref_i = 1'b0;
    rst_n = 1'b1;
    ph_cyc = 4; ph_val = 0;
    push_run(5,  "free_run", 1'b0, 1'b0, 1'b0);
    push_run(19, "free_run", 1'b0, 1'b0, 1'b0);
    push_run(20, "free_run", 1'b0, 1'b0, 1'b0);
    push_run(36, "free_run", 1'b0, 1'b0, 1'b0);

    // 2. First alignment with offset 3.
    cfg_lmfc_offset_i = W'(3);
    goto(40);
    c = cyc;
    push_run(c + 2, "pre_align", 1'b0, 1'b0, 1'b0);
    ph_cyc = c + 3; ph_val = 3;
    push_run(c + 3, "first_align", 1'b1, 1'b1, 1'b0);
    pulse(1);

    // 3. Ten in-phase SYSREFs every 64 cycles; one held high for 20 cycles.
    for (int i = 1; i <= 10; i++) begin
      t = c + 64 * i;
      goto(t);
      push_run(t + 3, "periodic", 1'b1, 1'b1, 1'b0);
      pulse((i == 5) ? 20 : 1);
    end

    // 4. One SYSREF 5 cycles late: misalign sticks and the counter reloads 3.
    ts = c + 64 * 11 + 5;
    goto(ts);
    push_run(ts + 2, "pre_shift", 1'b1, 1'b1, 1'b0);
    ph_cyc = ts + 3; ph_val = 3;
    push_run(ts + 3, "shift_realign", 1'b1, 1'b1, 1'b1);
    pulse(1);
    for (int i = 1; i <= 3; i++) begin
      goto(ts + 64 * i);
      push_run(ts + 64 * i + 3, "post_shift", 1'b1, 1'b1, 1'b1);
      pulse(1);
    end

    // 5. Clear, then one-shot alignment with offset 5 and ignored later pulses.
    k = ts + 64 * 3 + 40;
    goto(k);
    push_run(k + 1, "clear", 1'b0, 1'b0, 1'b0);
    clear_i = 1'b1;
    @(negedge coreclk);
    clear_i = 1'b0;
    cfg_oneshot_i = 1'b1;
    cfg_lmfc_offset_i = W'(5);
    p1 = k + 10;
    goto(p1);
    ph_cyc = p1 + 3; ph_val = 5;
    push_run(p1 + 3, "oneshot_align", 1'b1, 1'b1, 1'b0);
    pulse(1);
    p2 = p1 + 37;
    goto(p2);
    push_run(p2 + 3, "locked_ignore", 1'b1, 1'b1, 1'b0);
    pulse(1);
    p3 = p2 + 29;
    goto(p3);
    push_run(p3 + 3, "locked_ignore", 1'b1, 1'b1, 1'b0);
    pulse(1);
    // clear_i lands in the sysref_edge cycle while LOCKED.
    p4 = p3 + 50;
    goto(p4);
    push_run(p4 + 3, "clr_locked", 1'b0, 1'b0, 1'b0);
    pulse(1);
    goto(p4 + 2);
    clear_i = 1'b1;
    @(negedge coreclk);
    clear_i = 1'b0;
    // Same collision while WAIT, with an offset a load would visibly apply.
    cfg_oneshot_i = 1'b0;
    p5 = p4 + 20;
    goto(p5);
    cfg_lmfc_offset_i = W'((int'(exp_cnt(p5 + 3)) + 8) % P);
    push_run(p5 + 3, "clr_wait", 1'b0, 1'b0, 1'b0);
    pulse(1);
    goto(p5 + 2);
    clear_i = 1'b1;
    @(negedge coreclk);
    clear_i = 1'b0;
    push_run(p5 + 12, "still_wait", 1'b0, 1'b0, 1'b0);

    // 6. Offset 20 is out of range for P=16: align to 0.
    cfg_lmfc_offset_i = W'(20);
    p6 = p5 + 30;
    goto(p6);
    ph_cyc = p6 + 3; ph_val = 0;
    push_run(p6 + 3, "off_oor", 1'b1, 1'b1, 1'b0);
    pulse(1);
    // In phase with offset 0 means the counter sits at 15 on the edge.
    p7 = p6 + 64;
    goto(p7);
    push_run(p7 + 2, "off0_pre", 1'b1, 1'b1, 1'b0);
    push_run(p7 + 3, "off0_inphase", 1'b1, 1'b1, 1'b0);
    pulse(1);

    // Offset 15, the largest legal value.
    k2 = p7 + 20;
    goto(k2);
    clear_i = 1'b1;
    @(negedge coreclk);
    clear_i = 1'b0;
    cfg_lmfc_offset_i = W'(15);
    p8 = k2 + 10;
    goto(p8);
    ph_cyc = p8 + 3; ph_val = 15;
    push_run(p8 + 3, "off15", 1'b1, 1'b1, 1'b0);
    pulse(1);

    // Asynchronous reset mid-run; SYSREF high through release gives one edge.
    r = p8 + 20;
    goto(r);
    push(r + 1, "mid_reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(r + 2, "mid_reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    sysref_i = 1'b1;
    cfg_lmfc_offset_i = W'(7);
    goto(r + 3);
    rst_n = 1'b1;
    ph_cyc = r + 3; ph_val = 0;
    push_run(r + 5, "post_rst", 1'b0, 1'b0, 1'b0);
    ph_cyc = r + 6; ph_val = 7;
    push_run(r + 6, "rst_sysref", 1'b1, 1'b1, 1'b0);
    push_run(r + 20, "one_edge", 1'b1, 1'b1, 1'b0);
    goto(r + 24);
    sysref_i = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge coreclk);
    while (sbq.size() > 0) begin
      total++; bad++;
      $display("FAIL %0s: check for cycle %0d never reached", sbq[0].nm, sbq[0].at);
      void'(sbq.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
